// File: rtl/serial_adder_n_if.sv
// Operand/result bundle for serial_adder_n: request side (start, sub, a, b, c_in)
// and registered result side (busy, done, s, c_out, ovf).
interface serial_adder_n_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             c_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] s;
  logic             c_out;
  logic             ovf;

  modport master (
    output start, sub, a, b, c_in,
    input  busy, done, s, c_out, ovf
  );

  modport slave (
    input  start, sub, a, b, c_in,
    output busy, done, s, c_out, ovf
  );
endinterface

// File: rtl/serial_adder_n.sv
// Bit-serial WIDTH-bit adder/subtractor: one full-adder cell, one result bit per clock.
// Optional subtract mode is built only when SERIAL_ADDER_SUB_EN is defined.
module serial_adder_n #(
  parameter int WIDTH = 8
) (
  input  logic            clk,
  input  logic            rst,
  serial_adder_n_if.slave bus
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] a_reg, b_reg, res_reg, s_reg;
  logic             carry_reg, c_out_reg, ovf_reg;
  logic [CW-1:0]    cnt_reg;

  logic             sum_bit, carry_bit, last_bit, accept;
  logic [WIDTH-1:0] b_load;
  logic             carry_load;

`ifdef SERIAL_ADDER_SUB_EN
  // Subtract is a + ~b + 1: invert B on capture and force the initial carry.
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_b_inv
    assign b_load[gi] = bus.b[gi] ^ bus.sub;
  end
  assign carry_load = bus.sub ? 1'b1 : bus.c_in;
`else
  logic unused_sub;
  assign unused_sub = bus.sub;
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_b_pass
    assign b_load[gi] = bus.b[gi];
  end
  assign carry_load = bus.c_in;
`endif

  assign sum_bit   = a_reg[0] ^ b_reg[0] ^ carry_reg;
  assign carry_bit = (a_reg[0] & b_reg[0]) | (a_reg[0] & carry_reg) | (b_reg[0] & carry_reg);
  assign last_bit  = (cnt_reg == CW'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    accept     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (bus.start) begin
          accept     = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        if (last_bit) begin
          state_next = DONE;
        end
      end
      DONE: begin
        if (bus.start) begin
          accept     = 1'b1;
          state_next = RUN;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_reg     <= '0;
      b_reg     <= '0;
      res_reg   <= '0;
      s_reg     <= '0;
      carry_reg <= 1'b0;
      c_out_reg <= 1'b0;
      ovf_reg   <= 1'b0;
      cnt_reg   <= '0;
    end else if (accept) begin
      a_reg     <= bus.a;
      b_reg     <= b_load;
      carry_reg <= carry_load;
      cnt_reg   <= '0;
    end else if (state_reg == RUN) begin
      a_reg     <= a_reg >> 1;
      b_reg     <= b_reg >> 1;
      res_reg   <= {sum_bit, res_reg[WIDTH-1:1]};
      carry_reg <= carry_bit;
      cnt_reg   <= cnt_reg + 1'b1;
      // On the MSB, carry_reg still holds the carry into that bit.
      if (last_bit) begin
        s_reg     <= {sum_bit, res_reg[WIDTH-1:1]};
        c_out_reg <= carry_bit;
        ovf_reg   <= carry_reg ^ carry_bit;
      end
    end
  end

  assign bus.busy  = (state_reg == RUN);
  assign bus.done  = (state_reg == DONE);
  assign bus.s     = s_reg;
  assign bus.c_out = c_out_reg;
  assign bus.ovf   = ovf_reg;
endmodule

// File: tb/tb_serial_adder_n.sv
// Directed bench for serial_adder_n at WIDTH 8, 2 and 33: arithmetic, flags,
// handshake timing, input isolation during RUN, reset abort and back-to-back starts.
module tb_serial_adder_n;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  serial_adder_n_if #(.WIDTH(8))  if8 ();
  serial_adder_n_if #(.WIDTH(2))  if2 ();
  serial_adder_n_if #(.WIDTH(33)) if33 ();

  serial_adder_n #(.WIDTH(8))  u8  (.clk(clk), .rst(rst), .bus(if8));
  serial_adder_n #(.WIDTH(2))  u2  (.clk(clk), .rst(rst), .bus(if2));
  serial_adder_n #(.WIDTH(33)) u33 (.clk(clk), .rst(rst), .bus(if33));

  // Launch one 8-bit operation from IDLE/DONE and wait (bounded) for done.
  // lat counts edges from the accept edge up to the edge that raised done.
  task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic ci,
                      input logic sb, output int lat, output bit busy_ok);
    if8.a = a; if8.b = b; if8.c_in = ci; if8.sub = sb; if8.start = 1'b1;
    @(posedge clk); #1;
    if8.start = 1'b0;
    lat = 1;
    busy_ok = 1'b1;
    while (!if8.done && lat < 40) begin
      if (!if8.busy) busy_ok = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (if8.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b want=0", if8.busy); end
    checks++; if (if8.done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b want=0", if8.done); end
    checks++; if (if8.s !== 8'h00) begin errors++; $display("FAIL reset_s got=%h want=00", if8.s); end
    checks++; if ({if8.c_out, if8.ovf} !== 2'b00) begin errors++; $display("FAIL reset_flags got=%b want=00", {if8.c_out, if8.ovf}); end
    // rst must win over a simultaneous start.
    if8.a = 8'h11; if8.b = 8'h22; if8.start = 1'b1;
    @(posedge clk); #1;
    if8.start = 1'b0;
    rst = 1'b0;
    checks++; if (if8.busy !== 1'b0) begin errors++; $display("FAIL reset_over_start got=%b want=0", if8.busy); end
    @(posedge clk); #1;
  endtask

  task automatic test_add();
    logic [7:0] va [4] = '{8'h0F, 8'hFF, 8'h7F, 8'h80};
    logic [7:0] vb [4] = '{8'h01, 8'h01, 8'h01, 8'h80};
    logic       vc [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    logic [7:0] es [4] = '{8'h10, 8'h01, 8'h80, 8'h00};
    logic       eco[4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic       eov[4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    int lat;
    bit busy_ok;
    for (int i = 0; i < 4; i++) begin
      run8(va[i], vb[i], vc[i], 1'b0, lat, busy_ok);
      checks++; if (lat !== 9) begin errors++; $display("FAIL add%0d_latency got=%0d want=9", i, lat); end
      checks++; if (!busy_ok) begin errors++; $display("FAIL add%0d_busy got=dropped want=held", i); end
      checks++; if (if8.busy !== 1'b0) begin errors++; $display("FAIL add%0d_busy_at_done got=%b want=0", i, if8.busy); end
      checks++; if (if8.s !== es[i]) begin errors++; $display("FAIL add%0d_s got=%h want=%h", i, if8.s, es[i]); end
      checks++; if (if8.c_out !== eco[i]) begin errors++; $display("FAIL add%0d_c_out got=%b want=%b", i, if8.c_out, eco[i]); end
      checks++; if (if8.ovf !== eov[i]) begin errors++; $display("FAIL add%0d_ovf got=%b want=%b", i, if8.ovf, eov[i]); end
      $display("add%0d a=%h b=%h c_in=%b -> s=%h c_out=%b ovf=%b lat=%0d", i, va[i], vb[i], vc[i], if8.s, if8.c_out, if8.ovf, lat);
      @(posedge clk); #1;
      checks++; if (if8.done !== 1'b0) begin errors++; $display("FAIL add%0d_done_pulse got=%b want=0", i, if8.done); end
    end
  endtask

  task automatic test_sub();
    int lat;
    bit busy_ok;
    logic [7:0] e1, e2;
    logic       c1, c2;
`ifdef SERIAL_ADDER_SUB_EN
    e1 = 8'hFE; c1 = 1'b0; e2 = 8'h02; c2 = 1'b1;
`else
    e1 = 8'h0C; c1 = 1'b0; e2 = 8'h0C; c2 = 1'b0;
`endif
    run8(8'h05, 8'h07, 1'b0, 1'b1, lat, busy_ok);
    checks++; if (if8.s !== e1) begin errors++; $display("FAIL sub0_s got=%h want=%h", if8.s, e1); end
    checks++; if ({if8.c_out, if8.ovf} !== {c1, 1'b0}) begin errors++; $display("FAIL sub0_flags got=%b want=%b", {if8.c_out, if8.ovf}, {c1, 1'b0}); end
    $display("sub0 a=05 b=07 -> s=%h c_out=%b ovf=%b", if8.s, if8.c_out, if8.ovf);
    run8(8'h07, 8'h05, 1'b0, 1'b1, lat, busy_ok);
    checks++; if (if8.s !== e2) begin errors++; $display("FAIL sub1_s got=%h want=%h", if8.s, e2); end
    checks++; if ({if8.c_out, if8.ovf} !== {c2, 1'b0}) begin errors++; $display("FAIL sub1_flags got=%b want=%b", {if8.c_out, if8.ovf}, {c2, 1'b0}); end
    $display("sub1 a=07 b=05 -> s=%h c_out=%b ovf=%b", if8.s, if8.c_out, if8.ovf);
    if8.sub = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_ignore_inputs();
    int n = 0;
    if8.a = 8'h0F; if8.b = 8'h01; if8.c_in = 1'b0; if8.sub = 1'b0; if8.start = 1'b1;
    @(posedge clk); #1;
    if8.start = 1'b0; if8.a = 8'hAA; if8.b = 8'h55; if8.c_in = 1'b1; if8.sub = 1'b1;
    @(posedge clk); #1;
    if8.start = 1'b1;
    @(posedge clk); #1;
    if8.start = 1'b0;
    n = 2;
    while (!if8.done && n < 40) begin @(posedge clk); #1; n++; end
    checks++; if (n !== 8) begin errors++; $display("FAIL ignore_latency got=%0d want=8", n); end
    checks++; if (if8.s !== 8'h10) begin errors++; $display("FAIL ignore_s got=%h want=10", if8.s); end
    checks++; if ({if8.c_out, if8.ovf} !== 2'b00) begin errors++; $display("FAIL ignore_flags got=%b want=00", {if8.c_out, if8.ovf}); end
    $display("ignore a=0F b=01 (changed mid-run) -> s=%h", if8.s);
    if8.c_in = 1'b0; if8.sub = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_abort();
    int seen = 0;
    if8.a = 8'h33; if8.b = 8'h44; if8.start = 1'b1;
    @(posedge clk); #1;
    if8.start = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++; if (if8.busy !== 1'b0) begin errors++; $display("FAIL abort_busy got=%b want=0", if8.busy); end
    checks++; if (if8.done !== 1'b0) begin errors++; $display("FAIL abort_done got=%b want=0", if8.done); end
    checks++; if (if8.s !== 8'h00) begin errors++; $display("FAIL abort_s got=%h want=00", if8.s); end
    repeat (15) begin @(posedge clk); #1; if (if8.done) seen++; end
    checks++; if (seen !== 0) begin errors++; $display("FAIL abort_no_done got=%0d want=0", seen); end
    $display("abort rst on 3rd busy cycle -> busy=%b s=%h late_dones=%0d", if8.busy, if8.s, seen);
  endtask

  task automatic test_back_to_back_w8();
    logic [7:0] va [4] = '{8'h0F, 8'hFF, 8'h7F, 8'h80};
    logic [7:0] vb [4] = '{8'h01, 8'h01, 8'h01, 8'h80};
    logic       vc [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    logic [9:0] ex [4] = '{{8'h10, 2'b00}, {8'h01, 2'b10}, {8'h80, 2'b01}, {8'h00, 2'b11}};
    int prev = 0;
    int n;
    if8.a = va[0]; if8.b = vb[0]; if8.c_in = vc[0]; if8.start = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n = 0;
      @(posedge clk); #1;
      while (!if8.done && n < 40) begin @(posedge clk); #1; n++; end
      checks++; if (!if8.done) begin errors++; $display("FAIL b2b8_%0d_timeout got=no_done want=done", i); end
      if (i > 0) begin
        checks++; if (cyc - prev !== 9) begin errors++; $display("FAIL b2b8_%0d_gap got=%0d want=9", i, cyc - prev); end
      end
      checks++; if ({if8.s, if8.c_out, if8.ovf} !== ex[i]) begin errors++; $display("FAIL b2b8_%0d_result got=%h want=%h", i, {if8.s, if8.c_out, if8.ovf}, ex[i]); end
      checks++; if (if8.busy !== 1'b0) begin errors++; $display("FAIL b2b8_%0d_busy_done got=1 want=0", i); end
      $display("b2b8 %0d s=%h c_out=%b ovf=%b gap=%0d", i, if8.s, if8.c_out, if8.ovf, cyc - prev);
      prev = cyc;
      if (i < 3) begin if8.a = va[i+1]; if8.b = vb[i+1]; if8.c_in = vc[i+1]; end
      else if8.start = 1'b0;
    end
    if8.c_in = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back_w2();
    logic [1:0] va [3] = '{2'b01, 2'b11, 2'b10};
    logic [1:0] vb [3] = '{2'b01, 2'b01, 2'b10};
    logic       vc [3] = '{1'b0, 1'b0, 1'b1};
    logic [3:0] ex [3] = '{{2'b10, 2'b01}, {2'b00, 2'b10}, {2'b01, 2'b11}};
    int prev = 0;
    int n;
    if2.a = va[0]; if2.b = vb[0]; if2.c_in = vc[0]; if2.start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      n = 0;
      @(posedge clk); #1;
      while (!if2.done && n < 20) begin @(posedge clk); #1; n++; end
      checks++; if (!if2.done) begin errors++; $display("FAIL b2b2_%0d_timeout got=no_done want=done", i); end
      if (i > 0) begin
        checks++; if (cyc - prev !== 3) begin errors++; $display("FAIL b2b2_%0d_gap got=%0d want=3", i, cyc - prev); end
      end
      checks++; if ({if2.s, if2.c_out, if2.ovf} !== ex[i]) begin errors++; $display("FAIL b2b2_%0d_result got=%b want=%b", i, {if2.s, if2.c_out, if2.ovf}, ex[i]); end
      checks++; if (if2.busy !== 1'b0) begin errors++; $display("FAIL b2b2_%0d_busy_done got=1 want=0", i); end
      $display("b2b2 %0d s=%b c_out=%b ovf=%b gap=%0d", i, if2.s, if2.c_out, if2.ovf, cyc - prev);
      prev = cyc;
      if (i < 2) begin if2.a = va[i+1]; if2.b = vb[i+1]; if2.c_in = vc[i+1]; end
      else if2.start = 1'b0;
    end
    if2.c_in = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back_w33();
    logic [32:0] va [3] = '{33'h1_FFFF_FFFF, 33'h0_FFFF_FFFF, 33'h1_2345_6789};
    logic [32:0] vb [3] = '{33'h0_0000_0001, 33'h0_0000_0001, 33'h0_1111_1111};
    logic        vc [3] = '{1'b0, 1'b0, 1'b1};
    logic [34:0] ex [3] = '{{33'h0_0000_0000, 2'b10}, {33'h1_0000_0000, 2'b01}, {33'h1_3456_789B, 2'b00}};
    int prev = 0;
    int n;
    if33.a = va[0]; if33.b = vb[0]; if33.c_in = vc[0]; if33.start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      n = 0;
      @(posedge clk); #1;
      while (!if33.done && n < 80) begin @(posedge clk); #1; n++; end
      checks++; if (!if33.done) begin errors++; $display("FAIL b2b33_%0d_timeout got=no_done want=done", i); end
      if (i > 0) begin
        checks++; if (cyc - prev !== 34) begin errors++; $display("FAIL b2b33_%0d_gap got=%0d want=34", i, cyc - prev); end
      end
      checks++; if ({if33.s, if33.c_out, if33.ovf} !== ex[i]) begin errors++; $display("FAIL b2b33_%0d_result got=%h want=%h", i, {if33.s, if33.c_out, if33.ovf}, ex[i]); end
      checks++; if (if33.busy !== 1'b0) begin errors++; $display("FAIL b2b33_%0d_busy_done got=1 want=0", i); end
      $display("b2b33 %0d s=%h c_out=%b ovf=%b gap=%0d", i, if33.s, if33.c_out, if33.ovf, cyc - prev);
      prev = cyc;
      if (i < 2) begin if33.a = va[i+1]; if33.b = vb[i+1]; if33.c_in = vc[i+1]; end
      else if33.start = 1'b0;
    end
    if33.c_in = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    if8.start = 1'b0;  if8.sub = 1'b0;  if8.a = '0;  if8.b = '0;  if8.c_in = 1'b0;
    if2.start = 1'b0;  if2.sub = 1'b0;  if2.a = '0;  if2.b = '0;  if2.c_in = 1'b0;
    if33.start = 1'b0; if33.sub = 1'b0; if33.a = '0; if33.b = '0; if33.c_in = 1'b0;
    test_reset();
    test_add();
    test_sub();
    test_ignore_inputs();
    test_reset_abort();
    test_back_to_back_w8();
    test_back_to_back_w2();
    test_back_to_back_w33();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
